// File: rtl/spi_master_param.sv
// Parametrised SPI master: 1..WIDTH_MAX bit transfers, all four modes,
// programmable SCLK half-period, automatic chip-select.
module spi_master_param #(
  parameter int WIDTH_MAX = 32,
  parameter int DIV_WIDTH = 8,
  parameter int LEN_WIDTH = $clog2(WIDTH_MAX)
) (
  input  logic                 raw_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len_m1,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [WIDTH_MAX-1:0] data_tx,
  output logic [WIDTH_MAX-1:0] data_rx,
  output logic                 busy,
  output logic                 done,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int EW = $clog2(WIDTH_MAX) + 2;
  localparam logic [LEN_WIDTH-1:0] LMAX = LEN_WIDTH'(WIDTH_MAX - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t r_state;
  state_t w_next;

  logic [LEN_WIDTH-1:0] r_len_m1;
  logic                 r_cpol;
  logic                 r_cpha;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [WIDTH_MAX-1:0] r_tx;
  logic [WIDTH_MAX-1:0] r_rx;
  logic [WIDTH_MAX-1:0] r_data_rx;
  logic [EW-1:0]        r_edge;
  logic [LEN_WIDTH-1:0] r_bit;
  logic                 r_sclk;
  logic                 r_mosi;
  logic                 r_cs_n;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_tick;
  logic                 w_toggle;
  logic                 w_hold_end;
  logic                 w_lead;
  logic                 w_last;
  logic [EW-1:0]        w_k;
  logic [EW-1:0]        w_two_len;
  logic [LEN_WIDTH-1:0] w_len_cl;
  logic [LEN_WIDTH-1:0] w_bit_nx;
  logic [WIDTH_MAX-1:0] w_rx_sh;

  assign w_len_cl  = (len_m1 >= LMAX) ? LMAX : len_m1;
  assign w_k       = r_edge + EW'(1);
  assign w_two_len = ({{(EW-LEN_WIDTH){1'b0}}, r_len_m1} + EW'(1)) << 1;
  assign w_last    = (w_k == w_two_len);
  assign w_lead    = ~r_edge[0];
  assign w_tick    = (r_cnt == r_div);
  assign w_bit_nx  = r_bit - LEN_WIDTH'(1);
  assign w_rx_sh   = {r_rx[WIDTH_MAX-2:0], miso};

  always_ff @(posedge raw_clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // A start arriving alongside done is dropped; it is taken a cycle later.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_toggle   = 1'b0;
    w_hold_end = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && !r_done) begin
          w_accept = 1'b1;
          w_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (w_tick) begin
          w_toggle = 1'b1;
          if (w_last) w_next = HOLD;
        end
      end
      HOLD: begin
        if (w_tick) begin
          w_hold_end = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      r_len_m1  <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_data_rx <= '0;
      r_edge    <= '0;
      r_bit     <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        r_sclk <= cpol;
        r_mosi <= 1'b0;
        r_cs_n <= 1'b1;
      end
      if (w_accept) begin
        r_len_m1 <= w_len_cl;
        r_cpol   <= cpol;
        r_cpha   <= cpha;
        r_div    <= divisor;
        r_tx     <= data_tx;
        r_cnt    <= '0;
        r_edge   <= '0;
        r_rx     <= '0;
        r_bit    <= w_len_cl;
        r_cs_n   <= 1'b0;
        r_busy   <= 1'b1;
        r_mosi   <= cpha ? 1'b0 : data_tx[w_len_cl];
      end
      if (r_state != IDLE) begin
        r_cnt <= w_tick ? '0 : r_cnt + DIV_WIDTH'(1);
      end
      if (w_toggle) begin
        r_sclk <= ~r_sclk;
        r_edge <= w_k;
        if (w_lead) begin
          if (!r_cpha) begin
            r_rx <= w_rx_sh;
          end else begin
            r_mosi <= r_tx[r_bit];
            r_bit  <= w_bit_nx;
          end
        end else begin
          if (r_cpha) begin
            r_rx <= w_rx_sh;
          end else if (!w_last) begin
            r_mosi <= r_tx[w_bit_nx];
            r_bit  <= w_bit_nx;
          end
        end
      end
      if (w_hold_end) begin
        r_cs_n    <= 1'b1;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_mosi    <= 1'b0;
        r_sclk    <= r_cpol;
        r_data_rx <= r_rx;
      end
    end
  end

  assign data_rx = r_data_rx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cs_n    = r_cs_n;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: edge timing, data order and framing are
// predicted from the half-period arithmetic, not from DUT state.
module tb_spi_master_param;

  logic        raw_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  len_m1;
  logic        cpol;
  logic        cpha;
  logic [7:0]  divisor;
  logic [31:0] data_tx;
  logic [31:0] data_rx;
  logic        busy;
  logic        done;
  logic        cs_n;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        miso_drv;
  logic        loop_en;

  int checks = 0;
  int failures = 0;

  int o_busy, o_done, o_done_n, o_rise, o_tog, o_tog_bad, o_gap_bad;
  int o_mlead_bad, o_mtrail_bad;
  logic [31:0] o_rx, o_mseq, o_r_rx;
  logic o_cs0, o_busy0, o_sclk_end;
  logic o_r_cs, o_r_sclk, o_r_busy, o_r_done, o_r_mosi;

  assign miso = loop_en ? mosi : miso_drv;

  always #5 raw_clk = ~raw_clk;

  spi_master_param dut (
    .raw_clk(raw_clk), .reset(reset), .start(start), .len_m1(len_m1),
    .cpol(cpol), .cpha(cpha), .divisor(divisor), .data_tx(data_tx),
    .data_rx(data_rx), .busy(busy), .done(done), .cs_n(cs_n),
    .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  function automatic logic [31:0] lmask(input int len);
    logic [63:0] m;
    m = (64'd1 << len) - 64'd1;
    return m[31:0];
  endfunction

  // Bit j on the wire lands at position len-1-j of the received word.
  function automatic logic [31:0] model_rx(input logic [31:0] p, input int len);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < len; j++) r[len-1-j] = p[j];
    return r;
  endfunction

  task automatic run_xfer(input logic [4:0] l, input logic c_pol,
                          input logic c_pha, input logic [7:0] d,
                          input logic [31:0] tx, input logic lp,
                          input logic [31:0] p, input int rej_at,
                          input int rst_at, input int extra);
    int h, len, total, k, j, e, last_rise;
    logic ps, pm;
    h = int'(d) + 1;
    len = int'(l) + 1;
    total = (2 * len + 1) * h;
    o_busy = 0; o_done = 0; o_done_n = -1; o_rise = 0; o_tog = 0;
    o_tog_bad = 0; o_gap_bad = 0; o_mlead_bad = 0; o_mtrail_bad = 0;
    o_mseq = '0; o_rx = '0; last_rise = -1;
    @(negedge raw_clk);
    len_m1 = l; cpol = c_pol; cpha = c_pha; divisor = d;
    data_tx = tx; loop_en = lp; miso_drv = 1'b0; start = 1'b1;
    @(posedge raw_clk);
    ps = c_pol;
    pm = 1'b0;
    for (int n = 0; n < total + extra; n++) begin
      @(negedge raw_clk);
      if (n == 0) begin
        start = 1'b0; o_cs0 = cs_n; o_busy0 = busy;
      end
      if (n == rej_at) begin
        start = 1'b1; data_tx = 32'hFF; divisor = 8'd0;
        len_m1 = 5'd3; cpha = ~c_pha;
      end
      if (n == rej_at + 1) begin
        start = 1'b0; data_tx = tx; divisor = d;
        len_m1 = l; cpha = c_pha;
      end
      if (n == rst_at) reset = 1'b1;
      if (n == rst_at + 1) begin
        reset = 1'b0;
        o_r_cs = cs_n; o_r_sclk = sclk; o_r_busy = busy;
        o_r_done = done; o_r_rx = data_rx; o_r_mosi = mosi;
      end
      if (busy) o_busy++;
      if (done) begin
        o_done++; o_done_n = n; o_rx = data_rx;
      end
      if (sclk !== ps) begin
        o_tog++;
        if (n != o_tog * h) o_tog_bad++;
        if (sclk) begin
          if (last_rise >= 0 && n - last_rise != 2 * h) o_gap_bad++;
          last_rise = n;
          o_rise++;
        end
      end
      if (mosi !== pm && n != 0 && !done) begin
        k = n / h;
        if (n % h != 0 || k < 1 || k > 2 * len || k % 2 == 0) o_mlead_bad++;
        if (n % h != 0 || k < 2 || k > 2 * len || k % 2 == 1) o_mtrail_bad++;
      end
      e = n + 1;
      if (e % h == 0) begin
        k = e / h;
        if (k <= 2 * len && ((k % 2 == 1) == !c_pha)) begin
          j = c_pha ? (k - 2) / 2 : (k - 1) / 2;
          o_mseq[len-1-j] = mosi;
        end
      end
      if (!lp) begin
        k = (e + h - 1) / h;
        j = c_pha ? (k - 1) / 2 : k / 2;
        miso_drv = (j < len) ? p[j] : 1'b0;
      end
      ps = sclk;
      pm = mosi;
      o_sclk_end = sclk;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; len_m1 = '0; cpol = 1'b1; cpha = 1'b0;
    divisor = '0; data_tx = '0; miso_drv = 1'b0; loop_en = 1'b0;
    repeat (3) @(posedge raw_clk);
    @(negedge raw_clk);
    checks++;
    if (sclk !== 1'b0) begin
      failures++; $display("FAIL rst_sclk_in_reset got=%b exp=0", sclk);
    end
    cpol = 1'b0;
    reset = 1'b0;
    @(negedge raw_clk);
    checks++;
    if ({cs_n, sclk, mosi, busy, done} !== 5'b10000) begin
      failures++;
      $display("FAIL rst_outs got=%b exp=10000", {cs_n, sclk, mosi, busy, done});
    end
    checks++;
    if (data_rx !== 32'h0) begin
      failures++; $display("FAIL rst_data_rx got=%h exp=0", data_rx);
    end
  endtask

  task automatic test_mode0;
    run_xfer(5'd7, 1'b0, 1'b0, 8'd0, 32'hA5, 1'b1, '0, -5, -5, 4);
    checks++;
    if (o_rx !== 32'hA5) begin
      failures++; $display("FAIL m0_rx got=%h exp=000000a5", o_rx);
    end
    checks++;
    if (o_busy !== 17) begin
      failures++; $display("FAIL m0_busy got=%0d exp=17", o_busy);
    end
    checks++;
    if (o_mseq !== 32'hA5) begin
      failures++; $display("FAIL m0_mosi_seq got=%h exp=a5", o_mseq);
    end
    checks++;
    if (o_sclk_end !== 1'b0 || o_rise !== 8) begin
      failures++;
      $display("FAIL m0_sclk idle=%b rises=%0d exp idle=0 rises=8", o_sclk_end, o_rise);
    end
    checks++;
    if (o_done !== 1 || o_done_n !== 17) begin
      failures++;
      $display("FAIL m0_done cnt=%0d at=%0d exp cnt=1 at=17", o_done, o_done_n);
    end
    checks++;
    if (o_cs0 !== 1'b0 || o_busy0 !== 1'b1) begin
      failures++; $display("FAIL m0_start cs=%b busy=%b exp cs=0 busy=1", o_cs0, o_busy0);
    end
    checks++;
    if (o_tog_bad !== 0 || o_mtrail_bad !== 0) begin
      failures++;
      $display("FAIL m0_edges togbad=%0d mosibad=%0d exp 0 0", o_tog_bad, o_mtrail_bad);
    end
  endtask

  task automatic test_mode3;
    run_xfer(5'd15, 1'b1, 1'b1, 8'd3, 32'h1234, 1'b0, 32'hFFFF_FFFF, -5, -5, 12);
    checks++;
    if (o_rx !== 32'h0000FFFF) begin
      failures++; $display("FAIL m3_rx got=%h exp=0000ffff", o_rx);
    end
    checks++;
    if (o_sclk_end !== 1'b1 || o_gap_bad !== 0 || o_rise !== 16) begin
      failures++;
      $display("FAIL m3_sclk idle=%b gapbad=%0d rises=%0d exp 1 0 16",
               o_sclk_end, o_gap_bad, o_rise);
    end
    checks++;
    if (o_busy !== 132) begin
      failures++; $display("FAIL m3_busy got=%0d exp=132", o_busy);
    end
    checks++;
    if (o_mseq !== 32'h1234) begin
      failures++; $display("FAIL m3_mosi_seq got=%h exp=1234", o_mseq);
    end
  endtask

  task automatic test_mode1;
    run_xfer(5'd31, 1'b0, 1'b1, 8'd1, 32'h8000_0001, 1'b1, '0, -5, -5, 8);
    checks++;
    if (o_rx !== 32'h8000_0001) begin
      failures++; $display("FAIL m1_rx got=%h exp=80000001", o_rx);
    end
    checks++;
    if (o_done !== 1) begin
      failures++; $display("FAIL m1_done_count got=%0d exp=1", o_done);
    end
    checks++;
    if (o_mlead_bad !== 0) begin
      failures++; $display("FAIL m1_mosi_lead got=%0d off-edge changes exp=0", o_mlead_bad);
    end
    checks++;
    if (o_busy !== 130) begin
      failures++; $display("FAIL m1_busy got=%0d exp=130", o_busy);
    end
  endtask

  task automatic test_len1;
    run_xfer(5'd0, 1'b1, 1'b0, 8'd2, 32'h1, 1'b0, 32'h0, -5, -5, 10);
    checks++;
    if (o_rx !== 32'h0) begin
      failures++; $display("FAIL len1_rx got=%h exp=0", o_rx);
    end
    checks++;
    if (o_busy !== 9) begin
      failures++; $display("FAIL len1_busy got=%0d exp=9", o_busy);
    end
    checks++;
    if (o_tog !== 2 || o_rise !== 1) begin
      failures++; $display("FAIL len1_pulse tog=%0d rise=%0d exp 2 1", o_tog, o_rise);
    end
  endtask

  task automatic test_busy_reject;
    run_xfer(5'd7, 1'b0, 1'b0, 8'd1, 32'h96, 1'b1, '0, 6, -5, 40);
    checks++;
    if (o_rx !== 32'h96) begin
      failures++; $display("FAIL rej_rx got=%h exp=96", o_rx);
    end
    checks++;
    if (o_done !== 1 || o_busy !== 34 || o_tog !== 16) begin
      failures++;
      $display("FAIL rej_single done=%0d busy=%0d tog=%0d exp 1 34 16",
               o_done, o_busy, o_tog);
    end
  endtask

  task automatic test_reset_mid;
    run_xfer(5'd7, 1'b0, 1'b0, 8'd1, 32'hC3, 1'b1, '0, -5, 10, 6);
    checks++;
    if ({o_r_cs, o_r_sclk, o_r_busy, o_r_done, o_r_mosi} !== 5'b10000) begin
      failures++;
      $display("FAIL rstmid_outs got=%b exp=10000",
               {o_r_cs, o_r_sclk, o_r_busy, o_r_done, o_r_mosi});
    end
    checks++;
    if (o_r_rx !== 32'h0 || o_done !== 0) begin
      failures++; $display("FAIL rstmid_rx rx=%h done=%0d exp 0 0", o_r_rx, o_done);
    end
    run_xfer(5'd7, 1'b0, 1'b0, 8'd1, 32'h5C, 1'b1, '0, -5, -5, 4);
    checks++;
    if (o_rx !== 32'h5C || o_done !== 1) begin
      failures++; $display("FAIL rstmid_restart rx=%h done=%0d exp 5c 1", o_rx, o_done);
    end
  endtask

  task automatic test_back_to_back;
    logic got;
    run_xfer(5'd7, 1'b0, 1'b0, 8'd0, 32'h3C, 1'b1, '0, -5, -5, 1);
    checks++;
    if (o_done_n !== 17 || o_rx !== 32'h3C) begin
      failures++; $display("FAIL b2b_first at=%0d rx=%h exp 17 3c", o_done_n, o_rx);
    end
    start = 1'b1;
    data_tx = 32'h5A;
    @(negedge raw_clk);
    checks++;
    if (busy !== 1'b0 || cs_n !== 1'b1) begin
      failures++; $display("FAIL b2b_on_done busy=%b cs=%b exp 0 1", busy, cs_n);
    end
    @(negedge raw_clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || cs_n !== 1'b0) begin
      failures++; $display("FAIL b2b_next busy=%b cs=%b exp 1 0", busy, cs_n);
    end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge raw_clk);
      if (done) got = 1'b1;
    end
    checks++;
    if (got !== 1'b1 || data_rx !== 32'h5A) begin
      failures++; $display("FAIL b2b_second done=%b rx=%h exp 1 5a", got, data_rx);
    end
  endtask

  task automatic test_random;
    logic [4:0] l;
    logic [7:0] d;
    logic cp, ch, lp;
    logic [31:0] tx, p, exp_rx;
    int len, h;
    for (int it = 0; it < 8; it++) begin
      l = 5'($urandom_range(0, 31));
      d = 8'($urandom_range(0, 3));
      cp = 1'($urandom);
      ch = 1'($urandom);
      lp = 1'($urandom);
      tx = $urandom;
      p = $urandom;
      len = int'(l) + 1;
      h = int'(d) + 1;
      exp_rx = lp ? (tx & lmask(len)) : model_rx(p, len);
      run_xfer(l, cp, ch, d, tx, lp, p, -5, -5, 2 * h + 3);
      checks++;
      if (o_rx !== exp_rx) begin
        failures++; $display("FAIL rnd%0d_rx got=%h exp=%h", it, o_rx, exp_rx);
      end
      checks++;
      if (o_busy !== (2 * len + 1) * h || o_done_n !== (2 * len + 1) * h) begin
        failures++;
        $display("FAIL rnd%0d_timing busy=%0d done_at=%0d exp=%0d",
                 it, o_busy, o_done_n, (2 * len + 1) * h);
      end
      checks++;
      if (o_done !== 1 || o_tog !== 2 * len || o_tog_bad !== 0) begin
        failures++;
        $display("FAIL rnd%0d_edges done=%0d tog=%0d bad=%0d exp 1 %0d 0",
                 it, o_done, o_tog, o_tog_bad, 2 * len);
      end
      checks++;
      if (o_mseq !== (tx & lmask(len))) begin
        failures++;
        $display("FAIL rnd%0d_mosi got=%h exp=%h", it, o_mseq, tx & lmask(len));
      end
      checks++;
      if ((ch ? o_mlead_bad : o_mtrail_bad) !== 0 || o_sclk_end !== cp) begin
        failures++;
        $display("FAIL rnd%0d_mosi_edge lead=%0d trail=%0d idle=%b cpha=%b cpol=%b",
                 it, o_mlead_bad, o_mtrail_bad, o_sclk_end, ch, cp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode3;
    test_mode1;
    test_len1;
    test_busy_reject;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master for the soft-processor peripheral bus. It handles any transfer length from 1 to WIDTH_MAX bits, all four SPI modes (CPOL/CPHA) and a programmable SCLK divider. It drives chip-select automatically and receives the full transfer width. The CPU peripheral block starts it with a one-cycle strobe and reads the result after `done`.

## Interface
- WIDTH_MAX, 32: maximum transfer length in bits (≥2).
- DIV_WIDTH, 8: width of the clock divider input.
- LEN_WIDTH, $clog2(WIDTH_MAX): width of the length input.

Ports:
- raw_clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only while busy=0.
- len_m1  in  LEN_WIDTH  transfer length minus one (len = len_m1+1).
- cpol  in  1  SCLK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- divisor  in  DIV_WIDTH  half-period H = divisor+1 raw_clk cycles.
- data_tx  in  WIDTH_MAX  transmit word, right-justified; bit len-1 is sent first.
- data_rx  out  WIDTH_MAX  received word, right-justified, upper bits zero.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end.
- cs_n  out  1  chip select, active low.
- sclk, mosi  out  1  SPI clock and data out.
- miso  in  1  SPI data in.

## Operation
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - sclk tracks cpol each cycle; cs_n=1; mosi=0.
  - On start, latch len_m1, cpol, cpha, divisor and data_tx.
  - Move to SHIFT. Clear the edge counter and the divider counter.
- SHIFT:
  - The divider counts H cycles per half-period.
  - At each half-period end, sclk toggles. This is edge k, k=1..2·len.
  - Odd k is the leading edge; even k is the trailing edge.
- cpha=0:
  - mosi holds bit len-1 from the cycle cs_n falls.
  - miso is sampled into the rx shift register on leading edges.
  - mosi advances to the next bit on trailing edges, except the last trailing edge.
- cpha=1:
  - mosi advances on leading edges; the first leading edge presents bit len-1.
  - miso is sampled on trailing edges.
- Sampling: miso is captured on the same raw_clk edge that toggles sclk, using the pre-edge miso value.
- RX shift register: shifts left, LSB in. After len samples, it holds the received bits in [len-1:0].
- After edge 2·len, go to HOLD for one half-period with sclk=cpol.
- HOLD end:
  - cs_n=1, done=1, busy=0, return to IDLE.
  - data_rx loads the rx shift register with upper bits zeroed, in the same cycle as done.
  - data_rx is stable otherwise.
- start while busy=1 is ignored with no side effects. Input changes during a transfer have no effect.
- start in the same cycle as done is not accepted, because busy is still registered low only from that cycle. It is accepted one cycle later.
- Reset at any time:
  - Returns to IDLE next cycle.
  - cs_n=1, sclk=0, mosi=0, busy=0, done=0, data_rx=0.
  - An in-flight transfer is abandoned without a done pulse.

## Timing
- Reset values: cs_n=1, sclk=0, mosi=0, busy=0, done=0, data_rx=0.
- start sampled at edge T0; at T1, cs_n=0 and busy=1.
- SCLK edge k occurs at T1+k·H.
- cs_n rises and done pulses at T1+(2·len+1)·H.
- busy is high for exactly (2·len+1)·H cycles.
- SCLK period is 2·H raw_clk cycles with 50% duty cycle. divisor=0 gives raw_clk/2.
- Minimum gap between done and the next accepted start: 1 cycle.
- Width rules: divisor is unsigned; len_m1 ≥ WIDTH_MAX-1 is clamped to WIDTH_MAX-1.

## Test plan
- Mode 0, divisor=0, len_m1=7, data_tx=0xA5, mosi looped to miso:
  - data_rx=0x000000A5 and busy high 17 cycles.
  - mosi sequence is 1,0,1,0,0,1,0,1 and sclk idles at 0.
- Mode 3, divisor=3, len_m1=15, miso tied 1, data_tx=0x1234:
  - data_rx=0x0000FFFF, sclk idles at 1, period 8 cycles.
  - 16 rising edges and busy high 132 cycles.
- Mode 1, divisor=1, len_m1=31, loopback, data_tx=0x80000001:
  - data_rx=0x80000001, done pulses exactly once.
  - mosi changes only on leading edges.
- len_m1=0, mode 2, miso=0 → data_rx=0, busy high 3·H cycles, exactly one SCLK pulse.
- Busy rejection: pulse start again mid-transfer with data_tx=0xFF → the first transfer completes unchanged and no second transfer follows.
- Reset after edge 5 of an 8-bit transfer → next cycle cs_n=1, sclk=0, busy=0, data_rx=0, no done; a new start then works normally.
